// File: rtl/slider_cmd_gen_pkg.sv
// Shared slider settings: mode encodings, key indices and the
// autopilot axis helper used by the command generator.
package slider_cmd_gen_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_AUTO   = 2'd2
  } mode_e;

  localparam int KEY_GO   = 0;
  localparam int KEY_BACK = 1;
  localparam int KEY_UP   = 2;
  localparam int KEY_DOWN = 3;

  // Returns {positive, negative} move request for one axis
  function automatic logic [1:0] axisCmd(
    input logic [9:0] tgt,
    input logic [9:0] cur,
    input int         deadband
  );
    logic signed [10:0] e;
    logic signed [10:0] db;
    e  = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    db = 11'(deadband);
    return {e > db, e < -db};
  endfunction

endpackage

// File: rtl/slider_cmd_gen_key_debounce.sv
// One board key: two-flop synchronizer, then a tick-paced
// debouncer producing an active-high pressed level.
module key_debounce #(
  parameter int DB_TICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw_n,
  output logic pressed
);

  localparam int CW = $clog2(DB_TICKS + 1);

  logic [1:0]    syncQ;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) syncQ <= 2'b11;
    else        syncQ <= {syncQ[0], raw_n};
  end

  assign level = ~syncQ[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pressed <= 1'b0;
    end else if (tick) begin
      if (level != pressed) begin
        if (cnt == CW'(DB_TICKS - 1)) begin
          pressed <= level;
          cnt     <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/slider_cmd_gen.sv
// Slider motion command source: debounced keys or autopilot,
// one registered strobe per frame tick.
module slider_cmd_gen
  import slider_cmd_gen_pkg::*;
#(
  parameter int TICK_DIV     = 416667,
  parameter int DB_TICKS     = 2,
  parameter int DEADBAND     = 4,
  parameter int RESUME_TICKS = 120
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [3:0] iKEY_n,
  input  logic       iAuto_en,
  input  logic [9:0] iTarget_x,
  input  logic [9:0] iTarget_y,
  input  logic [9:0] iSlider_x,
  input  logic [9:0] iSlider_y,
  output logic       oSlider_go,
  output logic       oSlider_back,
  output logic       oSlider_up,
  output logic       oSlider_down,
  output logic [1:0] oMode
);

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RCW = $clog2(RESUME_TICKS + 1);

  logic [TCW-1:0] tickCnt;
  logic           tick;
  logic [3:0]     keys;
  logic           anyKey;
  mode_e          state, nextState;
  logic [RCW-1:0] resumeCnt, resumeNext;
  logic [1:0]     ax, ay;
  logic [3:0]     cmd;

  assign tick = (tickCnt == TCW'(TICK_DIV - 1));

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) tickCnt <= '0;
    else if (tick) tickCnt <= '0;
    else tickCnt <= tickCnt + 1'b1;
  end

  for (genvar i = 0; i < 4; i++) begin : gKey
    key_debounce #(.DB_TICKS(DB_TICKS)) uDb (
      .clk    (iVGA_CLK),
      .rst_n  (iRST_n),
      .tick   (tick),
      .raw_n  (iKEY_n[i]),
      .pressed(keys[i])
    );
  end

  assign anyKey = |keys;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= MODE_IDLE;
      resumeCnt <= '0;
    end else begin
      state     <= nextState;
      resumeCnt <= resumeNext;
    end
  end

  always_comb begin
    nextState  = state;
    resumeNext = resumeCnt;
    if (tick) begin
      case (state)
        MODE_IDLE: begin
          if (anyKey) begin
            nextState  = MODE_MANUAL;
            resumeNext = '0;
          end else if (iAuto_en) begin
            nextState = MODE_AUTO;
          end
        end
        MODE_AUTO: begin
          if (anyKey) begin
            nextState  = MODE_MANUAL;
            resumeNext = '0;
          end else if (!iAuto_en) begin
            nextState = MODE_IDLE;
          end
        end
        MODE_MANUAL: begin
          if (anyKey) begin
            resumeNext = '0;
          end else if (resumeCnt == RCW'(RESUME_TICKS - 1)) begin
            resumeNext = '0;
            nextState  = iAuto_en ? MODE_AUTO : MODE_IDLE;
          end else begin
            resumeNext = resumeCnt + 1'b1;
          end
        end
        default: nextState = MODE_IDLE;
      endcase
    end
  end

  assign ax = axisCmd(iTarget_x, iSlider_x, DEADBAND);
  assign ay = axisCmd(iTarget_y, iSlider_y, DEADBAND);

  // cmd = {go, back, up, down}
  always_comb begin
    cmd = 4'b0000;
    unique case (1'b1)
      (state == MODE_MANUAL): begin
        cmd[3] = keys[KEY_GO]   & ~keys[KEY_BACK];
        cmd[2] = keys[KEY_BACK] & ~keys[KEY_GO];
        cmd[1] = keys[KEY_UP]   & ~keys[KEY_DOWN];
        cmd[0] = keys[KEY_DOWN] & ~keys[KEY_UP];
      end
      (state == MODE_AUTO): begin
        cmd[3] = ax[1];
        cmd[2] = ax[0];
        cmd[1] = ay[0];
        cmd[0] = ay[1];
      end
      default: cmd = 4'b0000;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      {oSlider_go, oSlider_back, oSlider_up, oSlider_down} <= 4'b0000;
    end else begin
      {oSlider_go, oSlider_back, oSlider_up, oSlider_down} <=
        tick ? cmd : 4'b0000;
    end
  end

  assign oMode = state;

endmodule

// File: tb/tb_slider_cmd_gen.sv
// Scoreboard bench for slider_cmd_gen with a short tick
// (TICK_DIV=4) and directed key/autopilot scenarios.
module tb_slider_cmd_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] keyN;
  logic       autoEn;
  logic [9:0] tx, ty, sx, sy;
  logic       go, back, up, down;
  logic [1:0] mode;

  int         checks = 0;
  int         failures = 0;
  int         k;
  logic       sbOn = 1'b0;
  logic [3:0] q[$];

  always #5 clk = ~clk;

  slider_cmd_gen #(
    .TICK_DIV    (4),
    .DB_TICKS    (2),
    .DEADBAND    (4),
    .RESUME_TICKS(3)
  ) dut (
    .iVGA_CLK    (clk),
    .iRST_n      (rst_n),
    .iKEY_n      (keyN),
    .iAuto_en    (autoEn),
    .iTarget_x   (tx),
    .iTarget_y   (ty),
    .iSlider_x   (sx),
    .iSlider_y   (sy),
    .oSlider_go  (go),
    .oSlider_back(back),
    .oSlider_up  (up),
    .oSlider_down(down),
    .oMode       (mode)
  );

  // Posedges since last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [3:0] strb;
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        strb = {go, back, up, down};
        if (strb != 4'b0000) begin
          chk("strobe_phase", k % 4, 0);
          chk("strobe_exclusive",
              int'((go & back) | (up & down)), 0);
          if (sbOn) begin
            if (q.size() == 0) begin
              chk("unexpected_strobe", int'(strb), 0);
            end else begin
              e = q.pop_front();
              chk("strobe_value", int'(strb), int'(e));
            end
          end
        end
      end
    end
  endtask

  task automatic waitCyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Expect exactly n strobes of value e (none if e == 0)
  task automatic window(input int n, input logic [3:0] e);
    if (e != 4'b0000)
      for (int i = 0; i < n; i++) q.push_back(e);
    sbOn = 1'b1;
    waitCyc(4 * n);
    sbOn = 1'b0;
    chk("missing_strobes", q.size(), 0);
    q.delete();
  endtask

  initial begin
    bit seen;
    rst_n  = 1'b0;
    keyN   = 4'hF;
    autoEn = 1'b0;
    tx = 10'd300; ty = 10'd200;
    sx = 10'd300; sy = 10'd200;
    fork monitor(); join_none

    waitCyc(3);
    chk("reset_strobes", int'({go, back, up, down}), 0);
    chk("reset_mode", mode, 0);
    rst_n = 1'b1;

    // Idle, no keys, autopilot off
    window(10, 4'b0000);
    chk("idle_mode", mode, 0);

    // KEY[0] held
    keyN = 4'hE;
    waitCyc(20);
    chk("manual_mode", mode, 1);
    window(4, 4'b1000);

    // KEY[0] and KEY[1] together
    keyN = 4'hC;
    waitCyc(20);
    chk("opposed_mode", mode, 1);
    window(4, 4'b0000);

    // Release, autopilot on
    keyN = 4'hF;
    autoEn = 1'b1;
    sx = 10'd290; sy = 10'd210;
    waitCyc(40);
    chk("auto_mode", mode, 2);
    window(3, 4'b1010);
    sx = 10'd297; sy = 10'd204;
    window(2, 4'b0000);
    sx = 10'd295; sy = 10'd205;
    window(2, 4'b1010);
    sx = 10'd304; sy = 10'd196;
    window(2, 4'b0000);
    sx = 10'd305; sy = 10'd195;
    window(2, 4'b0101);

    // KEY[3] overrides autopilot
    keyN = 4'h7;
    waitCyc(20);
    chk("override_mode", mode, 1);
    window(3, 4'b0001);
    keyN = 4'hF;
    waitCyc(12);
    chk("resume_wait_mode", mode, 1);
    waitCyc(28);
    chk("resume_mode", mode, 2);

    // One-tick bounce on KEY[2]
    sx = 10'd300; sy = 10'd200;
    waitCyc(8);
    sbOn = 1'b1;
    keyN = 4'hB;
    waitCyc(4);
    keyN = 4'hF;
    waitCyc(20);
    sbOn = 1'b0;
    chk("bounce_mode", mode, 2);

    // Reset while a strobe is high
    sx = 10'd290; sy = 10'd210;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (go) seen = 1'b1;
    end
    chk("strobe_before_reset", int'(seen), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_strobes", int'({go, back, up, down}), 0);
    chk("async_reset_mode", mode, 0);
    waitCyc(2);
    rst_n = 1'b1;
    sbOn = 1'b1;
    waitCyc(3);
    chk("post_reset_mode_k3", mode, 0);
    waitCyc(1);
    chk("post_reset_mode_k4", mode, 2);
    waitCyc(3);
    sbOn = 1'b0;
    window(2, 4'b1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
